instruction_fetch_unit: RTL and testbench

Fetch stage of the RV32IM pipeline. It holds the program counter, issues read requests to the instruction memory/cache, and presents the fetched instruction and its PC to the IF/ID pipeline register. It applies branch redirects from EX, hazard stalls, and memory wait cycles, and converts wrong-path fetches into NOP bubbles. It also drives the global BUSYWAIT that freezes the pipeline registers during an instruction miss.

---
 rtl/instruction_fetch_unit_pkg.sv | 13 +
 rtl/instruction_fetch_unit_pc_select.sv | 46 ++++
 rtl/instruction_fetch_unit.sv | 84 ++++++++
 tb/tb_instruction_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        FETCH_BOOT          = 2'd0,
        FETCH_RUN           = 2'd1,
        FETCH_REDIRECT_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_pc_select.sv
// Combinational next-PC and redirect-register selection for the fetch stage.
module pc_select_unit
    import instruction_fetch_unit_pkg::*;
(
    input  fetch_state_e state,
    input  logic [31:0]  pc,
    input  logic [31:0]  redirect,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    input  logic         stall,
    input  logic         mem_busy,
    output logic [31:0]  pc_next,
    output logic [31:0]  redirect_next
);

    always_comb begin
        pc_next       = pc;
        redirect_next = redirect;
        case (state)
            FETCH_RUN: begin
                if (mem_busy) begin
                    if (branch_taken) begin
                        redirect_next = branch_target;
                    end
                end else if (branch_taken) begin
                    pc_next = branch_target;
                end else if (!stall) begin
                    pc_next = pc + 32'd4;
                end
            end
            FETCH_REDIRECT_WAIT: begin
                // A branch in the completion cycle still wins over the older pending target.
                if (branch_taken) begin
                    redirect_next = branch_target;
                end
                if (!mem_busy) begin
                    pc_next = branch_taken ? branch_target : redirect;
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage: PC, instruction requests, redirect handling and squash to NOP.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] OUT_INSTRUCTION,
    output logic [31:0] OUT_PC,
    output logic        BUSYWAIT
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_q, redirect_d;
    logic         imem_read_q, imem_read_d;
    logic [31:0]  target_aligned;

    assign target_aligned = BRANCH_TARGET & ~32'h3;

    pc_select_unit u_pc_select (
        .state         (state_q),
        .pc            (pc_q),
        .redirect      (redirect_q),
        .branch_taken  (BRANCH_TAKEN),
        .branch_target (target_aligned),
        .stall         (STALL),
        .mem_busy      (IMEM_BUSYWAIT),
        .pc_next       (pc_d),
        .redirect_next (redirect_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (IMEM_BUSYWAIT && BRANCH_TAKEN) begin
                    state_d = FETCH_REDIRECT_WAIT;
                end
            end
            FETCH_REDIRECT_WAIT: begin
                if (!IMEM_BUSYWAIT) begin
                    state_d = FETCH_RUN;
                end
            end
            default: begin
                state_d = FETCH_BOOT;
            end
        endcase
        imem_read_d = (state_d != FETCH_BOOT);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= FETCH_BOOT;
            pc_q        <= RESET_PC;
            redirect_q  <= 32'h0000_0000;
            imem_read_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            imem_read_q <= imem_read_d;
        end
    end

    assign IMEM_READ    = imem_read_q;
    assign IMEM_ADDRESS = pc_q;
    assign OUT_PC       = pc_q;
    assign BUSYWAIT     = imem_read_q & IMEM_BUSYWAIT;

    // Anything fetched outside normal run, or on the wrong path of a taken branch, becomes a bubble.
    assign OUT_INSTRUCTION = ((state_q != FETCH_RUN) || BRANCH_TAKEN) ? NOP : IMEM_READDATA;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios then random traffic.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        STALL;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] OUT_INSTRUCTION;
    logic [31:0] OUT_PC;
    logic        BUSYWAIT;

    instruction_fetch_unit dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .BRANCH_TAKEN    (BRANCH_TAKEN),
        .BRANCH_TARGET   (BRANCH_TARGET),
        .STALL           (STALL),
        .IMEM_READ       (IMEM_READ),
        .IMEM_ADDRESS    (IMEM_ADDRESS),
        .IMEM_READDATA   (IMEM_READDATA),
        .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
        .OUT_INSTRUCTION (OUT_INSTRUCTION),
        .OUT_PC          (OUT_PC),
        .BUSYWAIT        (BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory contents: words 10, 11, 12, ... at the bottom, an address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr < 32'h40) return 32'd10 + (addr >> 2);
        return {addr[15:0], ~addr[15:0]};
    endfunction

    assign IMEM_READDATA = mem_word(IMEM_ADDRESS);

    typedef struct {
        logic        rd;
        logic [31:0] pc;
        logic        bw;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model of the fetch stage's architectural behaviour.
    logic [31:0] m_pc;
    logic [31:0] m_pending;
    bit          m_booting;
    bit          m_waiting;

    task automatic model_reset();
        m_pc      = 32'h0;
        m_pending = 32'h0;
        m_booting = 1'b1;
        m_waiting = 1'b0;
    endtask

    task automatic apply(input bit bt, input logic [31:0] tgt, input bit stall, input bit busy);
        exp_t        e;
        logic [31:0] tgt_w;
        BRANCH_TAKEN  = bt;
        BRANCH_TARGET = tgt;
        STALL         = stall;
        IMEM_BUSYWAIT = busy;
        e.rd    = !m_booting;
        e.pc    = m_pc;
        e.bw    = e.rd && busy;
        e.instr = (m_booting || m_waiting || bt) ? NOP_WORD : mem_word(m_pc);
        sb.push_back(e);
        tgt_w = {tgt[31:2], 2'b00};
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_waiting) begin
            if (bt) m_pending = tgt_w;
            if (!busy) begin
                m_pc      = m_pending;
                m_waiting = 1'b0;
            end
        end else if (busy) begin
            if (bt) begin
                m_pending = tgt_w;
                m_waiting = 1'b1;
            end
        end else if (bt) begin
            m_pc = tgt_w;
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
        @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation, compare mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        bit   bad;
        #2;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            bad = 1'b0;
            n_vec++;
            if (IMEM_READ !== e.rd) begin
                bad = 1'b1;
                $display("FAIL imem_read: got %b expected %b", IMEM_READ, e.rd);
            end
            if (OUT_PC !== e.pc || IMEM_ADDRESS !== e.pc) begin
                bad = 1'b1;
                $display("FAIL pc: out_pc %h addr %h expected %h", OUT_PC, IMEM_ADDRESS, e.pc);
            end
            if (BUSYWAIT !== e.bw) begin
                bad = 1'b1;
                $display("FAIL busywait: got %b expected %b", BUSYWAIT, e.bw);
            end
            if (OUT_INSTRUCTION !== e.instr) begin
                bad = 1'b1;
                $display("FAIL instr: got %h expected %h", OUT_INSTRUCTION, e.instr);
            end
            if (bad) n_mis++;
            $display("txn %0d pc=%h instr=%h rd=%b bw=%b", n_vec, OUT_PC, OUT_INSTRUCTION, IMEM_READ, BUSYWAIT);
        end
    end

    initial begin
        RESET         = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'h0;
        STALL         = 1'b0;
        IMEM_BUSYWAIT = 1'b1;
        #1 RESET = 1'b1;
        #1;
        check("reset_instr", OUT_INSTRUCTION, NOP_WORD);
        check("reset_pc", OUT_PC, 32'h0);
        check("reset_read", {31'b0, IMEM_READ}, 32'h0);
        check("reset_busywait", {31'b0, BUSYWAIT}, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();

        // Boot, then sequential hits at 0, 4, 8.
        apply(0, 32'h0, 0, 0);
        apply(0, 32'h0, 0, 0);
        apply(0, 32'h0, 0, 0);
        // Three-cycle miss at 8, then completion.
        repeat (3) apply(0, 32'h0, 0, 1);
        apply(0, 32'h0, 0, 0);
        // Branch on hit with a misaligned target, then an aligned one.
        apply(1, 32'h103, 0, 0);
        apply(1, 32'h100, 0, 0);
        // Branch during a miss: held, completion emits NOP, then target.
        apply(1, 32'h200, 0, 1);
        repeat (2) apply(0, 32'h0, 0, 1);
        apply(0, 32'h0, 0, 0);
        apply(0, 32'h0, 0, 0);
        // Stall at the top of memory, then wrap to 0.
        apply(1, 32'hFFFF_FFFC, 0, 0);
        repeat (2) apply(0, 32'h0, 1, 0);
        apply(0, 32'h0, 0, 0);
        apply(0, 32'h0, 0, 0);
        // Branch beats stall.
        apply(1, 32'h40, 1, 0);
        apply(0, 32'h0, 0, 0);
        // Reset in the middle of a pending redirect.
        apply(0, 32'h0, 0, 1);
        apply(1, 32'h500, 0, 1);
        BRANCH_TAKEN  = 1'b0;
        IMEM_BUSYWAIT = 1'b1;
        #3 RESET = 1'b1;
        #1;
        check("midreset_read", {31'b0, IMEM_READ}, 32'h0);
        check("midreset_busywait", {31'b0, BUSYWAIT}, 32'h0);
        check("midreset_pc", OUT_PC, 32'h0);
        check("midreset_instr", OUT_INSTRUCTION, NOP_WORD);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        apply(0, 32'h0, 0, 0);
        apply(0, 32'h0, 0, 0);
        apply(0, 32'h0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit          bt;
            bit          st;
            bit          bz;
            logic [31:0] tg;
            bt = ($urandom_range(99) < 15);
            st = ($urandom_range(99) < 20);
            bz = ($urandom_range(99) < 30);
            tg = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
            apply(bt, tg, st, bz);
        end

        BRANCH_TAKEN  = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        STALL         = 1'b0;
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge CLK);
        #3;
        if (sb.size() > 0) begin
            n_mis++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
